// File: rtl/gpu_wb_arb.sv
// Register-file write-port arbiter with load/divide scoreboard for the GPU execute pipe.
// Latency: a grant in cycle N drives rf_we/rf_reg/rf_dat in cycle N+1; sbwait is combinational.
// Backpressure: ALU/imm writes never stall; ld/div hold one entry each, ready = empty or draining.
// Optional build macro GPU_WB_BYPASS_EN: a register granted this cycle drops out of sbwait at once.
module gpu_wb_arb #(
  parameter int DW   = 32,
  parameter int REGW = 5
) (
  input  logic            sys_clk,
  input  logic            reset_n,
  input  logic            imm_we,
  input  logic [REGW-1:0] imm_reg,
  input  logic [DW-1:0]   imm_dat,
  input  logic            alu_we,
  input  logic [REGW-1:0] alu_reg,
  input  logic [DW-1:0]   alu_dat,
  input  logic            ld_valid,
  input  logic [REGW-1:0] ld_reg,
  input  logic [DW-1:0]   ld_dat,
  output logic            ld_ready,
  input  logic            div_valid,
  input  logic [REGW-1:0] div_reg,
  input  logic [DW-1:0]   div_dat,
  output logic            div_ready,
  input  logic            sb_set,
  input  logic [REGW-1:0] sb_set_reg,
  input  logic            chk_src_en,
  input  logic [REGW-1:0] chk_src_reg,
  input  logic            chk_dst_en,
  input  logic [REGW-1:0] chk_dst_reg,
  output logic            sbwait,
  output logic            rf_we,
  output logic [REGW-1:0] rf_reg,
  output logic [DW-1:0]   rf_dat,
  output logic [1:0]      err,
  input  logic            err_clr
);

  localparam int NREG = 1 << REGW;

  // Round-robin pointer between the two buffered sources.
  typedef enum logic {RR_LD = 1'b0, RR_DIV = 1'b1} rr_e;
  rr_e rr_q, rr_d;

  logic            ld_full, div_full;
  logic [REGW-1:0] ld_reg_q, div_reg_q;
  logic [DW-1:0]   ld_dat_q, div_dat_q;
  logic            buf_ok, gnt_ld, gnt_div;
  logic [NREG-1:0] pend_q, pend_d, wait_mask;
  logic [1:0]      err_d;

  // Grant selection: direct writes always win, buffered slots share leftover cycles.
  always_comb begin
    buf_ok  = ~alu_we & ~imm_we;
    gnt_ld  = buf_ok & ld_full  & (~div_full | (rr_q == RR_LD));
    gnt_div = buf_ok & div_full & (~ld_full  | (rr_q == RR_DIV));
  end

  // A slot can take a new entry in the same cycle its current one drains.
  assign ld_ready  = ~ld_full  | gnt_ld;
  assign div_ready = ~div_full | gnt_div;

  // Pointer moves to the other source after every buffered grant.
  always_comb begin
    rr_d = rr_q;
    if (gnt_ld)       rr_d = RR_DIV;
    else if (gnt_div) rr_d = RR_LD;
  end

  // Pointer register.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) rr_q <= RR_LD;
    else          rr_q <= rr_d;
  end

  // Load and divide holding slots.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_full   <= 1'b0;
      ld_reg_q  <= '0;
      ld_dat_q  <= '0;
      div_full  <= 1'b0;
      div_reg_q <= '0;
      div_dat_q <= '0;
    end else begin
      if (ld_valid && ld_ready) begin
        ld_full  <= 1'b1;
        ld_reg_q <= ld_reg;
        ld_dat_q <= ld_dat;
      end else if (gnt_ld) begin
        ld_full  <= 1'b0;
      end
      if (div_valid && div_ready) begin
        div_full  <= 1'b1;
        div_reg_q <= div_reg;
        div_dat_q <= div_dat;
      end else if (gnt_div) begin
        div_full  <= 1'b0;
      end
    end
  end

  // Registered RF write port; address/data hold when nothing is granted.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we  <= 1'b0;
      rf_reg <= '0;
      rf_dat <= '0;
    end else begin
      rf_we <= 1'b1;
      if (alu_we) begin
        rf_reg <= alu_reg;
        rf_dat <= alu_dat;
      end else if (imm_we) begin
        rf_reg <= imm_reg;
        rf_dat <= imm_dat;
      end else if (gnt_ld) begin
        rf_reg <= ld_reg_q;
        rf_dat <= ld_dat_q;
      end else if (gnt_div) begin
        rf_reg <= div_reg_q;
        rf_dat <= div_dat_q;
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

  // Scoreboard next state: buffered grants clear, a new issue sets (set wins).
  always_comb begin
    pend_d = pend_q;
    if (gnt_ld)  pend_d[ld_reg_q]  = 1'b0;
    if (gnt_div) pend_d[div_reg_q] = 1'b0;
    if (sb_set)  pend_d[sb_set_reg] = 1'b1;
  end

  // Sticky error flags; a new error in the clear cycle survives the clear.
  always_comb begin
    err_d = err_clr ? 2'b00 : err;
    if (alu_we && imm_we)               err_d[0] = 1'b1;
    if (sb_set && pend_q[sb_set_reg])   err_d[1] = 1'b1;
  end

  // Scoreboard and error registers.
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= '0;
      err    <= 2'b00;
    end else begin
      pend_q <= pend_d;
      err    <= err_d;
    end
  end

  // Hazard view of the scoreboard; bypass build hides registers being written now.
  always_comb begin
    wait_mask = pend_q;
`ifdef GPU_WB_BYPASS_EN
    if (gnt_ld)  wait_mask[ld_reg_q]  = 1'b0;
    if (gnt_div) wait_mask[div_reg_q] = 1'b0;
`else
    wait_mask = pend_q;
`endif
  end

  assign sbwait = (chk_src_en & wait_mask[chk_src_reg]) |
                  (chk_dst_en & wait_mask[chk_dst_reg]);

endmodule

// File: tb/tb_gpu_wb_arb.sv
// Randomized and directed bench for gpu_wb_arb with a queue-based reference model.
// Expected RF writes go into a scoreboard queue; a monitor pops them as rf_we appears.
// Handshake, sbwait and err are compared every cycle against the model.
module tb_gpu_wb_arb;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
  } wr_t;

  logic        sys_clk = 1'b0;
  logic        reset_n;
  logic        imm_we, alu_we, ld_valid, div_valid, sb_set, chk_src_en, chk_dst_en, err_clr;
  logic [4:0]  imm_reg, alu_reg, ld_reg, div_reg, sb_set_reg, chk_src_reg, chk_dst_reg;
  logic [31:0] imm_dat, alu_dat, ld_dat, div_dat;
  logic        ld_ready, div_ready, sbwait, rf_we;
  logic [4:0]  rf_reg;
  logic [31:0] rf_dat;
  logic [1:0]  err;

  gpu_wb_arb #(.DW(32), .REGW(5)) dut (
    .sys_clk(sys_clk), .reset_n(reset_n),
    .imm_we(imm_we), .imm_reg(imm_reg), .imm_dat(imm_dat),
    .alu_we(alu_we), .alu_reg(alu_reg), .alu_dat(alu_dat),
    .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_dat(ld_dat), .ld_ready(ld_ready),
    .div_valid(div_valid), .div_reg(div_reg), .div_dat(div_dat), .div_ready(div_ready),
    .sb_set(sb_set), .sb_set_reg(sb_set_reg),
    .chk_src_en(chk_src_en), .chk_src_reg(chk_src_reg),
    .chk_dst_en(chk_dst_en), .chk_dst_reg(chk_dst_reg),
    .sbwait(sbwait), .rf_we(rf_we), .rf_reg(rf_reg), .rf_dat(rf_dat),
    .err(err), .err_clr(err_clr)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model state
  wr_t        exp_q[$];
  wr_t        ld_q[$];
  wr_t        div_q[$];
  bit  [31:0] m_pend;
  bit  [1:0]  m_err;
  bit         m_div_next;
  logic [4:0]  last_reg;
  logic [31:0] last_dat;
  bit         ld_acc, div_acc;
  int         n_chk = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    ld_q.delete();
    div_q.delete();
    m_pend = '0;
    m_err = 2'b00;
    m_div_next = 1'b0;
    last_reg = '0;
    last_dat = '0;
    ld_acc = 1'b0;
    div_acc = 1'b0;
  endtask

  task automatic idle();
    imm_we = 0; alu_we = 0; ld_valid = 0; div_valid = 0; sb_set = 0;
    chk_src_en = 0; chk_dst_en = 0; err_clr = 0;
  endtask

  // One clock: evaluate model at the falling edge, compare, advance model.
  task automatic tick();
    bit pick_ld, pick_div, buf_ok, e_ldr, e_divr, e_wait;
    bit [31:0] mask;
    bit [31:0] pend_old;
    @(negedge sys_clk);
    if (!reset_n) begin
      chk("rst_rf_we", rf_we, 0);
      chk("rst_rf_reg", rf_reg, 0);
      chk("rst_rf_dat", rf_dat, 0);
      chk("rst_err", err, 0);
      chk("rst_ld_ready", ld_ready, 1);
      chk("rst_div_ready", div_ready, 1);
      chk("rst_sbwait", sbwait, 0);
      model_reset();
    end else begin
      buf_ok = !alu_we && !imm_we;
      pick_ld = 0;
      pick_div = 0;
      if (buf_ok && ld_q.size() > 0 && div_q.size() > 0) begin
        if (m_div_next) pick_div = 1; else pick_ld = 1;
      end else if (buf_ok && ld_q.size() > 0) pick_ld = 1;
      else if (buf_ok && div_q.size() > 0) pick_div = 1;
      e_ldr  = (ld_q.size() == 0) || pick_ld;
      e_divr = (div_q.size() == 0) || pick_div;
      mask = m_pend;
`ifdef GPU_WB_BYPASS_EN
      if (pick_ld)  mask[ld_q[0].r] = 0;
      if (pick_div) mask[div_q[0].r] = 0;
`endif
      e_wait = (chk_src_en && mask[chk_src_reg]) || (chk_dst_en && mask[chk_dst_reg]);
      chk("ld_ready", ld_ready, e_ldr);
      chk("div_ready", div_ready, e_divr);
      chk("sbwait", sbwait, e_wait);
      chk("err", err, m_err);
      if (alu_we)        exp_q.push_back('{alu_reg, alu_dat});
      else if (imm_we)   exp_q.push_back('{imm_reg, imm_dat});
      else if (pick_ld)  exp_q.push_back(ld_q[0]);
      else if (pick_div) exp_q.push_back(div_q[0]);
      pend_old = m_pend;
      if (err_clr) m_err = 2'b00;
      if (alu_we && imm_we) m_err[0] = 1;
      if (sb_set && pend_old[sb_set_reg]) m_err[1] = 1;
      if (pick_ld)  begin m_pend[ld_q[0].r] = 0;  void'(ld_q.pop_front());  m_div_next = 1; end
      if (pick_div) begin m_pend[div_q[0].r] = 0; void'(div_q.pop_front()); m_div_next = 0; end
      if (sb_set) m_pend[sb_set_reg] = 1;
      ld_acc  = ld_valid && e_ldr;
      div_acc = div_valid && e_divr;
      if (ld_acc)  ld_q.push_back('{ld_reg, ld_dat});
      if (div_acc) div_q.push_back('{div_reg, div_dat});
    end
    @(posedge sys_clk);
    #1;
  endtask

  // Monitor: every RF write must match the oldest expected write; idle cycles hold.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (reset_n) begin
        if (rf_we) begin
          if (exp_q.size() == 0) chk("rf_we_unexpected", 1, 0);
          else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("rf_reg", rf_reg, e.r);
            chk("rf_dat", rf_dat, e.d);
            last_reg = e.r;
            last_dat = e.d;
          end
        end else begin
          chk("rf_reg_hold", rf_reg, last_reg);
          chk("rf_dat_hold", rf_dat, last_dat);
        end
      end
    end
  end

  task automatic rand_inputs();
    alu_we = ($urandom_range(0, 3) == 0);
    alu_reg = $urandom_range(0, 31); alu_dat = $urandom;
    imm_we = ($urandom_range(0, 4) == 0);
    imm_reg = $urandom_range(0, 31); imm_dat = $urandom;
    if (!ld_valid || ld_acc) begin
      ld_valid = $urandom_range(0, 1); ld_reg = $urandom_range(0, 7); ld_dat = $urandom;
    end
    if (!div_valid || div_acc) begin
      div_valid = $urandom_range(0, 1); div_reg = $urandom_range(0, 7); div_dat = $urandom;
    end
    sb_set = ($urandom_range(0, 3) == 0); sb_set_reg = $urandom_range(0, 7);
    chk_src_en = $urandom_range(0, 1); chk_src_reg = $urandom_range(0, 7);
    chk_dst_en = $urandom_range(0, 1); chk_dst_reg = $urandom_range(0, 7);
    err_clr = ($urandom_range(0, 15) == 0);
  endtask

  task automatic do_reset(input int n);
    reset_n = 0;
    idle();
    model_reset();
    for (int i = 0; i < n; i++) tick();
    reset_n = 1;
  endtask

  initial begin
    int nl, nd;
    imm_reg = 0; imm_dat = 0; alu_reg = 0; alu_dat = 0; ld_reg = 0; ld_dat = 0;
    div_reg = 0; div_dat = 0; sb_set_reg = 0; chk_src_reg = 0; chk_dst_reg = 0;
    idle();
    reset_n = 0;
    model_reset();
    #1;
    do_reset(2);

    // Pending r5, load returns two cycles later, source check held on r5
    chk_src_en = 1; chk_src_reg = 5;
    sb_set = 1; sb_set_reg = 5; tick();
    sb_set = 0; tick();
    tick();
    ld_valid = 1; ld_reg = 5; ld_dat = 32'h5555_aaaa; tick();
    ld_valid = 0;
    for (int i = 0; i < 4; i++) tick();
    idle();

    // Four loads and four divides back to back: alternating grants
    nl = 0; nd = 0;
    ld_valid = 1; ld_reg = 1; ld_dat = 32'h100;
    div_valid = 1; div_reg = 2; div_dat = 32'h200;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ld_acc) begin nl++; ld_reg = 5'(1 + nl); ld_dat = 32'h100 + nl; end
      if (div_acc) begin nd++; div_reg = 5'(9 + nd); div_dat = 32'h200 + nd; end
      if (nl >= 4) ld_valid = 0;
      if (nd >= 4) div_valid = 0;
    end
    idle();

    // ALU streak while the load slot is occupied
    ld_valid = 1; ld_reg = 3; ld_dat = 32'h33; tick();
    ld_reg = 4; ld_dat = 32'h44;
    alu_we = 1;
    for (int i = 0; i < 3; i++) begin alu_reg = 5'(i); alu_dat = 32'(i + 16); tick(); end
    alu_we = 0; tick();
    ld_valid = 0;
    for (int i = 0; i < 3; i++) tick();

    // ALU/imm collision, then clear
    alu_we = 1; alu_reg = 1; alu_dat = 32'h11;
    imm_we = 1; imm_reg = 2; imm_dat = 32'h22; tick();
    idle(); tick();
    err_clr = 1; tick();
    err_clr = 0; tick();

    // Double issue to r7
    sb_set = 1; sb_set_reg = 7; tick(); tick();
    sb_set = 0; tick(); tick();

    // Random traffic with a reset in the middle
    for (int i = 0; i < 1500; i++) begin rand_inputs(); tick(); end
    do_reset(2);
    chk_src_en = 1; chk_src_reg = 7; tick();
    for (int i = 0; i < 1500; i++) begin rand_inputs(); tick(); end

    // Drain both slots and let the last write land
    idle();
    for (int i = 0; i < 10; i++) tick();
    chk("drain_exp_q", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
